apb_rr_arbiter: RTL and testbench

Shares one downstream APB slave bus among NREQ upstream APB requesters (e.g. CPU, debug, DMA) in a single clock domain. It serialises transactions with round-robin fairness and regenerates the full APB SETUP/ACCESS sequence downstream from registered copies of the winning request. It sits in front of peripheral buses or in front of a clock-crossing bridge when several masters need the same peripheral space.

---
 rtl/apb_rr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter
//   Shares one downstream APB slave among NREQ upstream APB requesters using
//   round-robin arbitration. The winning request is registered and replayed
//   downstream as a full SETUP/ACCESS sequence. The requester then gets a
//   one-cycle PREADY pulse in the DONE state.
//
// Ports
//   clk, reset_n      clock and asynchronous active-low reset
//   req_PADDR         packed upstream addresses, requester i at [i*AWIDTH +: AWIDTH]
//   req_PSEL          per-requester select (the only sequencing input)
//   req_PENABLE       per-requester enable, accepted but not used
//   req_PWRITE        per-requester write flag
//   req_PWDATA        packed upstream write data, requester i at [i*32 +: 32]
//   req_PREADY        per-requester completion pulse
//   req_PRDATA        shared read data, valid while any req_PREADY bit is set
//   out_*             downstream APB master port
//   grant             index of the current or most recent winner
//   busy              high whenever the FSM is not IDLE
module apb_rr_arbiter #(
  parameter int AWIDTH = 12,
  parameter int NREQ   = 2,
  localparam int GW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ*AWIDTH-1:0] req_PADDR,
  input  logic [NREQ-1:0]        req_PSEL,
  input  logic [NREQ-1:0]        req_PENABLE,
  input  logic [NREQ-1:0]        req_PWRITE,
  input  logic [NREQ*32-1:0]     req_PWDATA,
  output logic [NREQ-1:0]        req_PREADY,
  output logic [31:0]            req_PRDATA,
  output logic [AWIDTH-1:0]      out_PADDR,
  output logic                   out_PSEL,
  output logic                   out_PENABLE,
  input  logic                   out_PREADY,
  output logic                   out_PWRITE,
  output logic [31:0]            out_PWDATA,
  input  logic [31:0]            out_PRDATA,
  output logic [GW-1:0]          grant,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t state, state_nx;
  logic [GW-1:0] last, last_nx;
  logic [GW-1:0] grant_nx;
  logic [AWIDTH-1:0] paddr_nx;
  logic psel_nx, penable_nx, pwrite_nx, busy_nx;
  logic [31:0] pwdata_nx, prdata_nx;
  logic [NREQ-1:0] pready_nx;

  logic found;
  logic [GW-1:0] winner;
  logic [GW-1:0] scan_idx;
  int idx;

  // PENABLE from requesters carries no information the FSM needs.
  logic unused_penable;
  assign unused_penable = ^req_PENABLE;

  // Unpacked views of the packed request buses.
  logic [AWIDTH-1:0] paddr_arr  [NREQ];
  logic [31:0]       pwdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign paddr_arr[g]  = req_PADDR[g*AWIDTH +: AWIDTH];
    assign pwdata_arr[g] = req_PWDATA[g*32 +: 32];
  end

  // Round-robin scan: last+1, last+2, ... wrapping, first selected wins.
  // The last candidate examined is last itself, so a lone requester can
  // win back to back.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      scan_idx = GW'(idx);
      if (!found && req_PSEL[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nx   = state;
    last_nx    = last;
    grant_nx   = grant;
    paddr_nx   = out_PADDR;
    pwrite_nx  = out_PWRITE;
    pwdata_nx  = out_PWDATA;
    prdata_nx  = req_PRDATA;
    psel_nx    = 1'b0;
    penable_nx = 1'b0;
    pready_nx  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx  = SETUP;
          last_nx   = winner;
          grant_nx  = winner;
          paddr_nx  = paddr_arr[winner];
          pwrite_nx = req_PWRITE[winner];
          pwdata_nx = pwdata_arr[winner];
          psel_nx   = 1'b1;
        end
      end
      SETUP: begin
        state_nx   = ACCESS;
        psel_nx    = 1'b1;
        penable_nx = 1'b1;
      end
      ACCESS: begin
        psel_nx    = 1'b1;
        penable_nx = 1'b1;
        if (out_PREADY) begin
          state_nx         = DONE;
          psel_nx          = 1'b0;
          penable_nx       = 1'b0;
          pready_nx[grant] = 1'b1;
          // Writes leave the previously returned read data untouched.
          if (!out_PWRITE) prdata_nx = out_PRDATA;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= GW'(NREQ - 1);
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant       <= '0;
      out_PADDR   <= '0;
      out_PSEL    <= 1'b0;
      out_PENABLE <= 1'b0;
      out_PWRITE  <= 1'b0;
      out_PWDATA  <= '0;
      req_PREADY  <= '0;
      req_PRDATA  <= '0;
      busy        <= 1'b0;
    end else begin
      grant       <= grant_nx;
      out_PADDR   <= paddr_nx;
      out_PSEL    <= psel_nx;
      out_PENABLE <= penable_nx;
      out_PWRITE  <= pwrite_nx;
      out_PWDATA  <= pwdata_nx;
      req_PREADY  <= pready_nx;
      req_PRDATA  <= prdata_nx;
      busy        <= busy_nx;
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Testbench for apb_rr_arbiter: a two-requester instance driven from a
// cycle-by-cycle vector table plus hand sequences, and a three-requester
// instance for the wrap-around scan order.
module tb_apb_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- NREQ = 2 instance ----------------
  logic [23:0] paddr;
  logic [1:0]  psel, penable, pwrite;
  logic [63:0] pwdata;
  logic [1:0]  rpready;
  logic [31:0] rprdata;
  logic [11:0] o_addr;
  logic        o_psel, o_pen, o_wr;
  logic [31:0] o_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        gnt;
  logic        busy;

  apb_rr_arbiter #(.AWIDTH(12), .NREQ(2)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_PADDR(paddr), .req_PSEL(psel), .req_PENABLE(penable),
    .req_PWRITE(pwrite), .req_PWDATA(pwdata),
    .req_PREADY(rpready), .req_PRDATA(rprdata),
    .out_PADDR(o_addr), .out_PSEL(o_psel), .out_PENABLE(o_pen),
    .out_PREADY(s_ready), .out_PWRITE(o_wr), .out_PWDATA(o_wdata),
    .out_PRDATA(s_rdata), .grant(gnt), .busy(busy)
  );

  // ---------------- NREQ = 3 instance ----------------
  logic [35:0] paddr3;
  logic [2:0]  psel3, penable3, pwrite3;
  logic [95:0] pwdata3;
  logic [2:0]  rpready3;
  logic [31:0] rprdata3;
  logic [11:0] o_addr3;
  logic        o_psel3, o_pen3, o_wr3;
  logic [31:0] o_wdata3;
  logic        s_ready3;
  logic [31:0] s_rdata3;
  logic [1:0]  gnt3;
  logic        busy3;

  apb_rr_arbiter #(.AWIDTH(12), .NREQ(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .req_PADDR(paddr3), .req_PSEL(psel3), .req_PENABLE(penable3),
    .req_PWRITE(pwrite3), .req_PWDATA(pwdata3),
    .req_PREADY(rpready3), .req_PRDATA(rprdata3),
    .out_PADDR(o_addr3), .out_PSEL(o_psel3), .out_PENABLE(o_pen3),
    .out_PREADY(s_ready3), .out_PWRITE(o_wr3), .out_PWDATA(o_wdata3),
    .out_PRDATA(s_rdata3), .grant(gnt3), .busy(busy3)
  );

  // Inputs applied before an edge; expected outputs just after it.
  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  wr;
    logic [11:0] a0, a1;
    logic [31:0] d0, d1;
    logic        rdy;
    logic [31:0] srd;
    logic        e_psel, e_pen;
    logic [11:0] e_addr;
    logic        e_wr;
    logic [31:0] e_wdata;
    logic        e_grant;
    logic [1:0]  e_rpr;
    logic [31:0] e_rdata;
    logic        e_busy;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic        found;
    logic        exp_g;
    int          last_setup;
    logic [1:0]  exp3 [3];
    logic [11:0] addr3 [3];

    // Simultaneous writes (pointer starts at 1, so req0 first)
    vecs[0]  = '{2'b11, 2'b11, 12'h004, 12'h008, 32'h11, 32'h22, 1'b1, 32'hBAD0BAD0,
                 1'b1, 1'b0, 12'h004, 1'b1, 32'h11, 1'b0, 2'b00, 32'h0, 1'b1};
    vecs[1]  = '{2'b11, 2'b11, 12'h004, 12'h008, 32'h11, 32'h22, 1'b1, 32'hBAD0BAD0,
                 1'b1, 1'b1, 12'h004, 1'b1, 32'h11, 1'b0, 2'b00, 32'h0, 1'b1};
    vecs[2]  = '{2'b11, 2'b11, 12'h004, 12'h008, 32'h11, 32'h22, 1'b1, 32'hBAD0BAD0,
                 1'b0, 1'b0, 12'h004, 1'b1, 32'h11, 1'b0, 2'b01, 32'h0, 1'b1};
    vecs[3]  = '{2'b11, 2'b11, 12'h004, 12'h008, 32'h11, 32'h22, 1'b1, 32'hBAD0BAD0,
                 1'b0, 1'b0, 12'h004, 1'b1, 32'h11, 1'b0, 2'b00, 32'h0, 1'b0};
    vecs[4]  = '{2'b11, 2'b11, 12'h004, 12'h008, 32'h11, 32'h22, 1'b1, 32'hBAD0BAD0,
                 1'b1, 1'b0, 12'h008, 1'b1, 32'h22, 1'b1, 2'b00, 32'h0, 1'b1};
    vecs[5]  = '{2'b11, 2'b11, 12'h004, 12'h008, 32'h11, 32'h22, 1'b1, 32'hBAD0BAD0,
                 1'b1, 1'b1, 12'h008, 1'b1, 32'h22, 1'b1, 2'b00, 32'h0, 1'b1};
    vecs[6]  = '{2'b11, 2'b11, 12'h004, 12'h008, 32'h11, 32'h22, 1'b1, 32'hBAD0BAD0,
                 1'b0, 1'b0, 12'h008, 1'b1, 32'h22, 1'b1, 2'b10, 32'h0, 1'b1};
    vecs[7]  = '{2'b00, 2'b11, 12'h004, 12'h008, 32'h11, 32'h22, 1'b1, 32'hBAD0BAD0,
                 1'b0, 1'b0, 12'h008, 1'b1, 32'h22, 1'b1, 2'b00, 32'h0, 1'b0};
    // Single zero-wait read from req0
    vecs[8]  = '{2'b01, 2'b00, 12'h014, 12'h0C0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF,
                 1'b1, 1'b0, 12'h014, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b1};
    vecs[9]  = '{2'b01, 2'b00, 12'h014, 12'h0C0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF,
                 1'b1, 1'b1, 12'h014, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b1};
    vecs[10] = '{2'b01, 2'b00, 12'h014, 12'h0C0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF,
                 1'b0, 1'b0, 12'h014, 1'b0, 32'h0, 1'b0, 2'b01, 32'hDEADBEEF, 1'b1};
    vecs[11] = '{2'b00, 2'b00, 12'h014, 12'h0C0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF,
                 1'b0, 1'b0, 12'h014, 1'b0, 32'h0, 1'b0, 2'b00, 32'hDEADBEEF, 1'b0};

    exp3[0] = 2'd1; exp3[1] = 2'd2; exp3[2] = 2'd1;
    addr3[0] = 12'h111; addr3[1] = 12'h222; addr3[2] = 12'h111;

    reset_n = 1'b0;
    paddr = '0; psel = '0; penable = '0; pwrite = '0; pwdata = '0;
    s_ready = 1'b0; s_rdata = '0;
    paddr3 = {12'h222, 12'h111, 12'h000};
    psel3 = '0; penable3 = '0; pwrite3 = '0; pwdata3 = '0;
    s_ready3 = 1'b0; s_rdata3 = 32'h33;

    repeat (2) step();
    chk("reset psel", o_psel, 1'b0);
    chk("reset penable", o_pen, 1'b0);
    chk("reset paddr", o_addr, 12'h0);
    chk("reset pready", rpready, 2'b00);
    chk("reset prdata", rprdata, 32'h0);
    chk("reset grant", gnt, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset3 psel", o_psel3, 1'b0);
    chk("reset3 grant", gnt3, 2'd0);
    reset_n = 1'b1;

    // Table-driven part
    for (int i = 0; i < 12; i++) begin
      psel    = vecs[i].sel;
      penable = vecs[i].sel;
      pwrite  = vecs[i].wr;
      paddr   = {vecs[i].a1, vecs[i].a0};
      pwdata  = {vecs[i].d1, vecs[i].d0};
      s_ready = vecs[i].rdy;
      s_rdata = vecs[i].srd;
      step();
      chk($sformatf("v%0d psel", i), o_psel, vecs[i].e_psel);
      chk($sformatf("v%0d penable", i), o_pen, vecs[i].e_pen);
      chk($sformatf("v%0d paddr", i), o_addr, vecs[i].e_addr);
      chk($sformatf("v%0d pwrite", i), o_wr, vecs[i].e_wr);
      chk($sformatf("v%0d pwdata", i), o_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d grant", i), gnt, vecs[i].e_grant);
      chk($sformatf("v%0d req_pready", i), rpready, vecs[i].e_rpr);
      chk($sformatf("v%0d req_prdata", i), rprdata, vecs[i].e_rdata);
      chk($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
    end

    // Fairness: both requesters always pending, last grant was 0
    psel = 2'b11; penable = 2'b11; pwrite = 2'b00;
    paddr = {12'h0A1, 12'h0A0}; s_ready = 1'b1;
    last_setup = 0;
    for (int n = 0; n < 8; n++) begin
      found = 1'b0;
      for (int b = 0; b < 8 && !found; b++) begin
        s_rdata = 32'h1000 + n;
        step();
        if (o_psel && !o_pen) found = 1'b1;
      end
      chk($sformatf("fair%0d setup seen", n), found, 1'b1);
      if (found) begin
        exp_g = ((n % 2) == 0);
        chk($sformatf("fair%0d grant", n), gnt, exp_g);
        chk($sformatf("fair%0d paddr", n), o_addr, exp_g ? 12'h0A1 : 12'h0A0);
        if (n > 0) chk($sformatf("fair%0d gap", n), cyc - last_setup, 4);
        last_setup = cyc;
        step();
        step();
        chk($sformatf("fair%0d req_pready", n), rpready, exp_g ? 2'b10 : 2'b01);
        chk($sformatf("fair%0d req_prdata", n), rprdata, 32'h1000 + n);
      end
    end
    psel = 2'b00; penable = 2'b00;
    step();

    // Wait states: 5 ACCESS cycles with PREADY low, upstream changes ignored
    psel = 2'b01; penable = 2'b01; pwrite = 2'b01;
    paddr = {12'h0B0, 12'h3A0}; pwdata = {32'h0, 32'h5555AAAA};
    s_ready = 1'b0; s_rdata = 32'h0;
    step();
    chk("ws setup paddr", o_addr, 12'h3A0);
    chk("ws setup penable", o_pen, 1'b0);
    step();
    paddr = {12'h0B0, 12'hFFF}; pwdata = {32'h0, 32'h12345678};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ws%0d psel", k), o_psel, 1'b1);
      chk($sformatf("ws%0d penable", k), o_pen, 1'b1);
      chk($sformatf("ws%0d paddr", k), o_addr, 12'h3A0);
      chk($sformatf("ws%0d pwdata", k), o_wdata, 32'h5555AAAA);
      chk($sformatf("ws%0d req_pready", k), rpready, 2'b00);
      if (k < 4) step();
    end
    s_ready = 1'b1; s_rdata = 32'hCAFEF00D;
    step();
    chk("ws done req_pready", rpready, 2'b01);
    chk("ws done psel", o_psel, 1'b0);
    chk("ws write keeps prdata", rprdata, 32'h1007);
    psel = 2'b00; penable = 2'b00; pwrite = 2'b00;
    step();
    chk("ws single pulse", rpready, 2'b00);

    // Requester 1 drops PSEL after being granted: still completes
    psel = 2'b10; penable = 2'b10;
    paddr = {12'h0C8, 12'h000}; s_ready = 1'b1; s_rdata = 32'h5A5A5A5A;
    step();
    chk("drop setup grant", gnt, 1'b1);
    psel = 2'b00; penable = 2'b00;
    step();
    chk("drop access penable", o_pen, 1'b1);
    step();
    chk("drop req_pready", rpready, 2'b10);
    chk("drop req_prdata", rprdata, 32'h5A5A5A5A);
    step();
    chk("drop idle busy", busy, 1'b0);

    // Reset while waiting in ACCESS (last grant is 0 at that moment)
    psel = 2'b01; penable = 2'b01;
    paddr = {12'h0C8, 12'h100}; s_ready = 1'b0;
    step();
    step();
    chk("rst pre penable", o_pen, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst async psel", o_psel, 1'b0);
    chk("rst async penable", o_pen, 1'b0);
    chk("rst async paddr", o_addr, 12'h0);
    chk("rst async busy", busy, 1'b0);
    chk("rst async prdata", rprdata, 32'h0);
    #2;
    reset_n = 1'b1;
    psel = 2'b11; penable = 2'b11; s_ready = 1'b1; s_rdata = 32'h77;
    step();
    chk("post-rst grant (pointer reset)", gnt, 1'b0);
    chk("post-rst psel", o_psel, 1'b1);
    step();
    step();
    psel = 2'b00; penable = 2'b00;
    step();
    psel = 2'b10; penable = 2'b10;
    step();
    chk("post-rst req1 grant", gnt, 1'b1);
    psel = 2'b00; penable = 2'b00;
    repeat (3) step();

    // NREQ=3: pointer at 2 after reset, req1 and req2 pending
    psel3 = 3'b110; penable3 = 3'b110; s_ready3 = 1'b1;
    for (int n = 0; n < 3; n++) begin
      found = 1'b0;
      for (int b = 0; b < 8 && !found; b++) begin
        step();
        if (o_psel3 && !o_pen3) found = 1'b1;
      end
      chk($sformatf("n3_%0d setup seen", n), found, 1'b1);
      if (found) begin
        chk($sformatf("n3_%0d grant", n), gnt3, exp3[n]);
        chk($sformatf("n3_%0d paddr", n), o_addr3, addr3[n]);
        step();
        step();
        chk($sformatf("n3_%0d req_pready", n), rpready3, 3'b001 << exp3[n]);
        chk($sformatf("n3_%0d req_prdata", n), rprdata3, 32'h33);
      end
    end
    psel3 = 3'b000; penable3 = 3'b000;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
